// File: rtl/bcd_display_scan.sv
// Scans a packed BCD word onto a shared active-low 7-segment bus, one digit at a time.
// Outputs are registered with one cycle of latency. load is accepted every cycle and never back-pressured.
// Define BCD_SCAN_LZB_EN to blank leading zeros (digit 0 is never blanked).
module bcd_display_scan #(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    err
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   function automatic logic [6:0] f_decode(input logic [3:0] i_d);
      logic [6:0] v;
      case (i_d)
         4'd0:    v = 7'h40;
         4'd1:    v = 7'h79;
         4'd2:    v = 7'h24;
         4'd3:    v = 7'h30;
         4'd4:    v = 7'h19;
         4'd5:    v = 7'h12;
         4'd6:    v = 7'h02;
         4'd7:    v = 7'h78;
         4'd8:    v = 7'h00;
         4'd9:    v = 7'h10;
         default: v = 7'h3F;
      endcase
      return v;
   endfunction

   logic [4*NUM_DIGITS-1:0] r_data;
   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_err;

   logic                    w_wrap;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] w_data_nxt;
   logic [3:0]              w_digit;
   logic [NUM_DIGITS-1:0]   w_an_nxt;
   logic                    w_err_nxt;
   logic                    w_blank;
   logic [6:0]              w_seg_nxt;

   // Outputs are decoded from the post-edge state so a load or an index
   // advance shows up on the very edge that takes it.
   always_comb begin
      w_wrap     = (r_cnt == CNT_LAST);
      w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
      w_idx_nxt  = r_idx;
      if (w_wrap) begin
         w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      w_data_nxt = load ? bcd_in : r_data;
   end

   always_comb begin
      w_digit   = 4'd0;
      w_an_nxt  = '1;
      w_err_nxt = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == w_idx_nxt) begin
            w_digit     = w_data_nxt[4*i +: 4];
            w_an_nxt[i] = 1'b0;
         end
         if (w_data_nxt[4*i +: 4] > 4'd9) begin
            w_err_nxt = 1'b1;
         end
      end
   end

`ifdef BCD_SCAN_LZB_EN
   logic w_any_nz;

   // A '-' nibble is non-zero, so it also stops blanking of the digits below it.
   always_comb begin
      w_any_nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((IDX_W'(i) >= w_idx_nxt) && (w_data_nxt[4*i +: 4] != 4'd0)) begin
            w_any_nz = 1'b1;
         end
      end
      w_blank = (w_idx_nxt != '0) && !w_any_nz;
   end
`else
   always_comb begin
      w_blank = 1'b0;
   end
`endif

   always_comb begin
      w_seg_nxt = w_blank ? 7'h7F : f_decode(w_digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_cnt  <= '0;
         r_idx  <= '0;
         r_seg  <= 7'h7F;
         r_an   <= '1;
         r_err  <= 1'b0;
      end else begin
         r_data <= w_data_nxt;
         r_cnt  <= w_cnt_nxt;
         r_idx  <= w_idx_nxt;
         r_seg  <= w_seg_nxt;
         r_an   <= w_an_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign seg = r_seg;
   assign an  = r_an;
   assign err = r_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan (2 digits, 4-cycle refresh): table-driven vectors through a scoreboard,
// plus reset sequences. Expectations follow BCD_SCAN_LZB_EN when it is defined.
module tb_bcd_display_scan;

   localparam int ND = 2;
   localparam int RD = 4;
`ifdef BCD_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       load   = 1'b0;
   logic [7:0] bcd_in = 8'h00;
   logic [6:0] seg;
   logic [1:0] an;
   logic       err;

   bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .bcd_in (bcd_in),
      .seg    (seg),
      .an     (an),
      .err    (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [7:0] bcd;
      logic [6:0] seg;
      logic [6:0] seg_lzb;
      logic [1:0] an;
      logic       er;
   } vec_t;

   typedef struct {
      logic [6:0] seg;
      logic [1:0] an;
      logic       er;
      int         tag;
   } exp_t;

   vec_t vt [30];
   exp_t sb_q [$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string nm, input int tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, tag, got, want);
      end
   endtask

   task automatic push(input int tag, input logic [6:0] s, input logic [6:0] s_lzb,
                       input logic [1:0] a, input logic e);
      exp_t x;
      x.seg = LZB ? s_lzb : s;
      x.an  = a;
      x.er  = e;
      x.tag = tag;
      sb_q.push_back(x);
   endtask

   task automatic step_and_check();
      exp_t x;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard: got empty queue, want an entry");
      end else begin
         x = sb_q.pop_front();
         check("seg", x.tag, {1'b0, seg}, {1'b0, x.seg});
         check("an",  x.tag, {6'd0, an},  {6'd0, x.an});
         check("err", x.tag, {7'd0, err}, {7'd0, x.er});
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish, want finish before 50000");
      $fatal(1);
   end

   initial begin
      //          ld    bcd    seg    seg_lzb an     err
      vt[0]  = '{1'b0, 8'h00, 7'h40, 7'h40, 2'b10, 1'b0};
      vt[1]  = '{1'b1, 8'h57, 7'h78, 7'h78, 2'b10, 1'b0};
      vt[2]  = '{1'b0, 8'hFF, 7'h78, 7'h78, 2'b10, 1'b0};
      vt[3]  = '{1'b0, 8'hFF, 7'h12, 7'h12, 2'b01, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b01, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b01, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b01, 1'b0};
      vt[7]  = '{1'b0, 8'h00, 7'h78, 7'h78, 2'b10, 1'b0};
      vt[8]  = '{1'b1, 8'h0A, 7'h3F, 7'h3F, 2'b10, 1'b1};
      vt[9]  = '{1'b1, 8'h09, 7'h10, 7'h10, 2'b10, 1'b0};
      vt[10] = '{1'b0, 8'h00, 7'h10, 7'h10, 2'b10, 1'b0};
      vt[11] = '{1'b1, 8'h31, 7'h30, 7'h30, 2'b01, 1'b0};
      vt[12] = '{1'b1, 8'h05, 7'h40, 7'h7F, 2'b01, 1'b0};
      vt[13] = '{1'b0, 8'h00, 7'h40, 7'h7F, 2'b01, 1'b0};
      vt[14] = '{1'b1, 8'hA0, 7'h3F, 7'h3F, 2'b01, 1'b1};
      vt[15] = '{1'b1, 8'h05, 7'h12, 7'h12, 2'b10, 1'b0};
      vt[16] = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b10, 1'b0};
      vt[17] = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b10, 1'b0};
      vt[18] = '{1'b0, 8'h00, 7'h12, 7'h12, 2'b10, 1'b0};
      vt[19] = '{1'b0, 8'h00, 7'h40, 7'h7F, 2'b01, 1'b0};
      vt[20] = '{1'b1, 8'hF2, 7'h3F, 7'h3F, 2'b01, 1'b1};
      vt[21] = '{1'b1, 8'h44, 7'h19, 7'h19, 2'b01, 1'b0};
      vt[22] = '{1'b1, 8'h86, 7'h00, 7'h00, 2'b01, 1'b0};
      vt[23] = '{1'b1, 8'h23, 7'h30, 7'h30, 2'b10, 1'b0};
      vt[24] = '{1'b1, 8'h06, 7'h02, 7'h02, 2'b10, 1'b0};
      vt[25] = '{1'b1, 8'h61, 7'h79, 7'h79, 2'b10, 1'b0};
      vt[26] = '{1'b1, 8'h12, 7'h24, 7'h24, 2'b10, 1'b0};
      vt[27] = '{1'b1, 8'h06, 7'h40, 7'h7F, 2'b01, 1'b0};
      vt[28] = '{1'b1, 8'hB0, 7'h3F, 7'h3F, 2'b01, 1'b1};
      vt[29] = '{1'b0, 8'h00, 7'h3F, 7'h3F, 2'b01, 1'b1};

      // Reset held across edges with a load pending: reset must dominate.
      rst_n  = 1'b0;
      load   = 1'b1;
      bcd_in = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("rst_seg", k, {1'b0, seg}, 8'h7F);
         check("rst_an",  k, {6'd0, an},  8'h03);
         check("rst_err", k, {7'd0, err}, 8'h00);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 30; v++) begin
         load   = vt[v].ld;
         bcd_in = vt[v].bcd;
         push(v, vt[v].seg, vt[v].seg_lzb, vt[v].an, vt[v].er);
         step_and_check();
      end

      // Short asynchronous reset pulse mid-scan, between clock edges.
      load   = 1'b0;
      bcd_in = 8'h00;
      #2;
      rst_n = 1'b0;
      #1;
      check("pulse_seg", 0, {1'b0, seg}, 8'h7F);
      check("pulse_an",  0, {6'd0, an},  8'h03);
      check("pulse_err", 0, {7'd0, err}, 8'h00);
      #2;
      rst_n = 1'b1;

      push(100, 7'h40, 7'h40, 2'b10, 1'b0);
      push(101, 7'h40, 7'h40, 2'b10, 1'b0);
      push(102, 7'h40, 7'h40, 2'b10, 1'b0);
      push(103, 7'h40, 7'h7F, 2'b01, 1'b0);
      push(104, 7'h40, 7'h7F, 2'b01, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step_and_check();
      end

      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
